// File: rtl/mod_mul_unit.sv
// Bit-serial modular multiplier: result = (a * b) mod m, fixed 2W+1 cycle latency.
// Restoring reduction of a mod m, then MSB-first double-and-add over the bits of b.
module mod_mul_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] result,
  output logic         done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CntMax = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StRed, StMul, StFin} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  ar_q, ar_d;
  logic [W:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          done_q, done_d;

  logic [W:0] m_ext;
  logic       m_zero;
  logic [W:0] red_t, red_n;
  logic [W:0] mul_d, mul_dr, mul_s, mul_sr, mul_n;

  // Datapath: acc < m_q holds throughout, so W+1 bits hold every intermediate.
  always_comb begin
    m_ext  = {1'b0, m_q};
    m_zero = (m_q == '0);
    red_t  = (acc_q << 1) | {{W{1'b0}}, a_q[cnt_q]};
    red_n  = (red_t >= m_ext) ? (red_t - m_ext) : red_t;
    mul_d  = acc_q << 1;
    mul_dr = (mul_d >= m_ext) ? (mul_d - m_ext) : mul_d;
    mul_s  = mul_dr + {1'b0, ar_q};
    mul_sr = (mul_s >= m_ext) ? (mul_s - m_ext) : mul_s;
    mul_n  = b_q[cnt_q] ? mul_sr : mul_dr;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    ar_d     = ar_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          acc_d   = '0;
          cnt_d   = CntMax;
          done_d  = 1'b0;
          state_d = StRed;
        end
      end
      StRed: begin
        // Modulus zero is defined to yield zero, so the accumulator is pinned there.
        acc_d = m_zero ? '0 : red_n;
        if (cnt_q == '0) begin
          ar_d    = m_zero ? '0 : red_n[W-1:0];
          acc_d   = '0;
          cnt_d   = CntMax;
          state_d = StMul;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StMul: begin
        acc_d = m_zero ? '0 : mul_n;
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFin: begin
        result_d = acc_q[W-1:0];
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      ar_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      ar_q     <= ar_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mod_mul_unit.sv
// Directed bench for mod_mul_unit: latency, arithmetic, boundaries, abort and chained ops.
module tb_mod_mul_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] m;
  logic [31:0] result;
  logic        done;

  int tests_run;
  int tests_failed;

  mod_mul_unit #(.W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .m      (m),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1: start is sampled on the next edge; returns edges until done rises.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] im,
                        output logic [31:0] res, output int cycles, output logic done_at_start);
    a     = ia;
    b     = ib;
    m     = im;
    start = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    done_at_start = done;
    cycles        = 0;
    while (cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) break;
    end
    res = result;
  endtask

  task automatic test_reset();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_done: got %b want 1", done);
    end
    tests_run++;
    if (result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %0d want 0", result);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_done: got %b want 1", done);
    end
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int          cyc;
    logic        das;
    run_op(32'd3, 32'd5, 32'd7, res, cyc, das);
    tests_run++;
    if (das !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_fall: got %b want 0", das);
    end
    tests_run++;
    if (cyc != 65) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 65", cyc);
    end
    tests_run++;
    if (res !== 32'd1) begin
      tests_failed++;
      $display("FAIL basic_result: got %0d want 1", res);
    end
  endtask

  task automatic test_wide();
    logic [31:0] res;
    int          cyc;
    logic        das;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, res, cyc, das);
    tests_run++;
    if (res !== 32'd16 || cyc != 65) begin
      tests_failed++;
      $display("FAIL wide_max: got %0d (cycles %0d) want 16 (65)", res, cyc);
    end
    // 12345*6789 = 83810205 = 83*1000003 + 809956
    run_op(32'd12345, 32'd6789, 32'd1000003, res, cyc, das);
    tests_run++;
    if (res !== 32'd809956) begin
      tests_failed++;
      $display("FAIL wide_mid: got %0d want 809956", res);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] res;
    int          cyc;
    logic        das;
    run_op(32'd9, 32'd9, 32'd0, res, cyc, das);
    tests_run++;
    if (res !== 32'd0 || cyc != 65) begin
      tests_failed++;
      $display("FAIL m_zero: got %0d (cycles %0d) want 0 (65)", res, cyc);
    end
    run_op(32'd123, 32'd456, 32'd1, res, cyc, das);
    tests_run++;
    if (res !== 32'd0) begin
      tests_failed++;
      $display("FAIL m_one: got %0d want 0", res);
    end
    run_op(32'd77, 32'd0, 32'd100, res, cyc, das);
    tests_run++;
    if (res !== 32'd0) begin
      tests_failed++;
      $display("FAIL b_zero: got %0d want 0", res);
    end
    run_op(32'd5, 32'd1, 32'd3, res, cyc, das);
    tests_run++;
    if (res !== 32'd2) begin
      tests_failed++;
      $display("FAIL small: got %0d want 2", res);
    end
  endtask

  task automatic test_busy_inputs();
    int   rises;
    int   rise_cyc;
    logic prev;
    a     = 32'd3;
    b     = 32'd5;
    m     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    prev     = done;
    rises    = 0;
    rise_cyc = -1;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && prev === 1'b0) begin
        rises++;
        rise_cyc = cyc;
      end
      prev  = done;
      a     = $urandom;
      b     = $urandom;
      m     = $urandom;
      start = (cyc == 5 || cyc == 40) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    tests_run++;
    if (rises != 1 || rise_cyc != 65) begin
      tests_failed++;
      $display("FAIL busy_done_rises: got %0d at cycle %0d want 1 at 65", rises, rise_cyc);
    end
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("FAIL busy_result: got %0d want 1", result);
    end
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int          cyc;
    logic        das;
    a     = 32'd3;
    b     = 32'd5;
    m     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: got %b want 0", done);
    end
    reset = 1'b1;
    #2;
    tests_run++;
    if (done !== 1'b1 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_async: got done=%b result=%0d want 1/0", done, result);
    end
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(32'd2, 32'd10, 32'd1000, res, cyc, das);
    tests_run++;
    if (res !== 32'd20 || cyc != 65) begin
      tests_failed++;
      $display("FAIL abort_recover: got %0d (cycles %0d) want 20 (65)", res, cyc);
    end
  endtask

  // 3^13 mod 1000 with exponent bits 1101, LSB first, each op started right after done rises.
  task automatic test_back_to_back();
    logic [31:0] r;
    logic [31:0] base;
    logic [31:0] res;
    int          cyc;
    int          bad_lat;
    int          bad_acc;
    logic        das;
    bad_lat = 0;
    bad_acc = 0;
    r       = 32'd1;
    base    = 32'd3;
    run_op(r, base, 32'd1000, res, cyc, das);    // bit0: r = 3
    r = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    run_op(base, base, 32'd1000, res, cyc, das); // base = 9
    base = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    run_op(base, base, 32'd1000, res, cyc, das); // bit1=0: base = 81
    base = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    run_op(r, base, 32'd1000, res, cyc, das);    // bit2: r = 243
    r = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    tests_run++;
    if (r !== 32'd243) begin
      tests_failed++;
      $display("FAIL pow_partial: got %0d want 243", r);
    end
    run_op(base, base, 32'd1000, res, cyc, das); // base = 561
    base = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    run_op(r, base, 32'd1000, res, cyc, das);    // bit3: r = 323
    r = res;
    if (cyc != 65) bad_lat++;
    if (das !== 1'b0) bad_acc++;
    tests_run++;
    if (r !== 32'd323) begin
      tests_failed++;
      $display("FAIL pow_result: got %0d want 323", r);
    end
    tests_run++;
    if (bad_lat != 0) begin
      tests_failed++;
      $display("FAIL pow_latency: got %0d wrong latencies want 0", bad_lat);
    end
    tests_run++;
    if (bad_acc != 0) begin
      tests_failed++;
      $display("FAIL pow_b2b_accept: got %0d starts not accepted want 0", bad_acc);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    start        = 1'b0;
    a            = '0;
    b            = '0;
    m            = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wide();
    test_boundaries();
    test_busy_inputs();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
